// File: rtl/div_issue_ctrl.sv
// -----------------------------------------------------------------------------
// div_issue_ctrl
//
// Purpose:
//   This is the issue and sequencing stage that sits in front of the iterative
//   divider in the M-extension path. Tagged DIV/DIVU/REM/REMU requests are
//   buffered in a small FIFO and launched into the divider one at a time.
//   Two kinds of request are answered locally without using the divider:
//   divide-by-zero and signed overflow. Every request produces exactly one
//   tagged result on a valid/ready writeback port.
//
// Ports:
//   clk_i, rst_n_i    rising-edge clock; synchronous active-low reset
//   clk_en_i          clock enable; when low, all state is frozen
//   flush_i           pipeline flush; empties the FIFO and abandons work
//   req_*             request from the issue logic (valid/ready, op, rs1, rs2, tag)
//   div_*             launch interface to the divider (start pulse, held operands,
//                     done pulse, result)
//   res_*             writeback interface (valid/ready, data, tag)
//   busy_o            high while any work is buffered or in flight
// -----------------------------------------------------------------------------
module div_issue_ctrl #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4,
    parameter int DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             clk_en_i,
    input  logic             flush_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [1:0]       req_op_i,
    input  logic [XLEN-1:0]  req_dividend_i,
    input  logic [XLEN-1:0]  req_divisor_i,
    input  logic [TAG_W-1:0] req_tag_i,
    output logic             div_start_o,
    output logic [1:0]       div_op_o,
    output logic [XLEN-1:0]  div_dividend_o,
    output logic [XLEN-1:0]  div_divisor_o,
    input  logic             div_done_i,
    input  logic [XLEN-1:0]  div_result_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [XLEN-1:0]  res_data_o,
    output logic [TAG_W-1:0] res_tag_o,
    output logic             busy_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_RESULT,
        S_DRAIN
    } state_t;

    state_t            state_q, state_d;

    logic [1:0]        fifoOp_q       [DEPTH];
    logic [XLEN-1:0]   fifoDividend_q [DEPTH];
    logic [XLEN-1:0]   fifoDivisor_q  [DEPTH];
    logic [TAG_W-1:0]  fifoTag_q      [DEPTH];
    logic [PTR_W-1:0]  wrPtr_q, rdPtr_q;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [1:0]        divOp_q, divOp_d;
    logic [XLEN-1:0]   divDividend_q, divDividend_d;
    logic [XLEN-1:0]   divDivisor_q, divDivisor_d;
    logic [TAG_W-1:0]  curTag_q, curTag_d;
    logic [XLEN-1:0]   resData_q, resData_d;
    logic [TAG_W-1:0]  resTag_q, resTag_d;

    logic              fifoEmpty, fifoFull;
    logic              doPush, doPop;
    logic [1:0]        headOp;
    logic [XLEN-1:0]   headDividend, headDivisor;
    logic [TAG_W-1:0]  headTag;
    logic              divisorZero, signedOverflow, headSpecial;
    logic [XLEN-1:0]   specialResult;

    // FIFO occupancy flags and the push/pop qualifiers. Ready depends only on
    // the count so it never forms a loop with the requester's valid. A flush
    // suppresses both the push and the pop, since the FIFO is being cleared.
    always_comb begin
        fifoEmpty    = (count_q == '0);
        fifoFull     = (count_q == CNT_W'(DEPTH));
        req_ready_o  = !fifoFull;
        doPush       = req_valid_i && !fifoFull && !flush_i;
        doPop        = (state_q == S_IDLE) && !fifoEmpty && !flush_i;
        headOp       = fifoOp_q[rdPtr_q];
        headDividend = fifoDividend_q[rdPtr_q];
        headDivisor  = fifoDivisor_q[rdPtr_q];
        headTag      = fifoTag_q[rdPtr_q];
        count_d      = count_q + CNT_W'(doPush) - CNT_W'(doPop);
    end

    // Corner cases that RISC-V defines without a trap are resolved here.
    // op[0]=0 marks the signed ops (DIV, REM) and op[1]=1 marks remainders.
    // Only signed ops can overflow, and only for INT_MIN / -1.
    always_comb begin
        divisorZero    = (headDivisor == '0);
        signedOverflow = !headOp[0] && (headDividend == INT_MIN) && (headDivisor == '1);
        headSpecial    = divisorZero || signedOverflow;
        specialResult  = '0;
        if (divisorZero) begin
            specialResult = headOp[1] ? headDividend : '1;
        end else if (signedOverflow) begin
            specialResult = headOp[1] ? '0 : INT_MIN;
        end
    end

    // Next-state and datapath-register logic for the sequencer. A head entry
    // is only popped from IDLE, so a result handshake and the next pop can
    // never share a cycle. If a flush lands in WAIT on the same cycle the
    // divider finishes, the divider is already free, so we return straight
    // to IDLE rather than draining for a done pulse that will never arrive.
    always_comb begin
        state_d       = state_q;
        divOp_d       = divOp_q;
        divDividend_d = divDividend_q;
        divDivisor_d  = divDivisor_q;
        curTag_d      = curTag_q;
        resData_d     = resData_q;
        resTag_d      = resTag_q;
        case (state_q)
            S_IDLE: begin
                if (doPop) begin
                    if (headSpecial) begin
                        resData_d = specialResult;
                        resTag_d  = headTag;
                        state_d   = S_RESULT;
                    end else begin
                        divOp_d       = headOp;
                        divDividend_d = headDividend;
                        divDivisor_d  = headDivisor;
                        curTag_d      = headTag;
                        state_d       = S_LAUNCH;
                    end
                end
            end
            S_LAUNCH: begin
                state_d = flush_i ? S_DRAIN : S_WAIT;
            end
            S_WAIT: begin
                if (flush_i) begin
                    state_d = div_done_i ? S_IDLE : S_DRAIN;
                end else if (div_done_i) begin
                    resData_d = div_result_i;
                    resTag_d  = curTag_q;
                    state_d   = S_RESULT;
                end
            end
            S_RESULT: begin
                if (flush_i || res_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (div_done_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset wins over the clock enable; with the
    // enable low, nothing moves.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q       <= S_IDLE;
            divOp_q       <= '0;
            divDividend_q <= '0;
            divDivisor_q  <= '0;
            curTag_q      <= '0;
            resData_q     <= '0;
            resTag_q      <= '0;
        end else if (clk_en_i) begin
            state_q       <= state_d;
            divOp_q       <= divOp_d;
            divDividend_q <= divDividend_d;
            divDivisor_q  <= divDivisor_d;
            curTag_q      <= curTag_d;
            resData_q     <= resData_d;
            resTag_q      <= resTag_d;
        end
    end

    // FIFO control registers. Pointers wrap naturally because DEPTH is a power
    // of two. A flush discards every buffered entry by resetting the control
    // state; the stale storage contents are harmless.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else if (clk_en_i) begin
            if (flush_i) begin
                wrPtr_q <= '0;
                rdPtr_q <= '0;
                count_q <= '0;
            end else begin
                if (doPush) begin
                    wrPtr_q <= wrPtr_q + PTR_W'(1);
                end
                if (doPop) begin
                    rdPtr_q <= rdPtr_q + PTR_W'(1);
                end
                count_q <= count_d;
            end
        end
    end

    // FIFO storage. It needs no reset because an entry is only read after it
    // has been written.
    always_ff @(posedge clk_i) begin
        if (clk_en_i && doPush) begin
            fifoOp_q[wrPtr_q]       <= req_op_i;
            fifoDividend_q[wrPtr_q] <= req_dividend_i;
            fifoDivisor_q[wrPtr_q]  <= req_divisor_i;
            fifoTag_q[wrPtr_q]      <= req_tag_i;
        end
    end

    // The outputs are decoded directly from registered state, so the launch
    // pulse and the result valid are glitch-free.
    always_comb begin
        div_start_o    = (state_q == S_LAUNCH);
        div_op_o       = divOp_q;
        div_dividend_o = divDividend_q;
        div_divisor_o  = divDivisor_q;
        res_valid_o    = (state_q == S_RESULT);
        res_data_o     = resData_q;
        res_tag_o      = resTag_q;
        busy_o         = (state_q != S_IDLE) || !fifoEmpty;
    end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_div_issue_ctrl
//
// This is a directed bench for div_issue_ctrl. A behavioural divider answers
// launches after a fixed latency. Expected results are queued when each request
// is driven, and they are compared when writeback accepts a result.
// -----------------------------------------------------------------------------
module tb_div_issue_ctrl;

    localparam int XLEN  = 32;
    localparam int TAG_W = 4;
    localparam int DIV_LAT = 34;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  data;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             clkEn;
    logic             flush;
    logic             reqValid;
    logic             reqReady;
    logic [1:0]       reqOp;
    logic [XLEN-1:0]  reqDividend;
    logic [XLEN-1:0]  reqDivisor;
    logic [TAG_W-1:0] reqTag;
    logic             divStart;
    logic [1:0]       divOp;
    logic [XLEN-1:0]  divDividend;
    logic [XLEN-1:0]  divDivisor;
    logic             divDone;
    logic [XLEN-1:0]  divResult;
    logic             resValid;
    logic             resReady;
    logic [XLEN-1:0]  resData;
    logic [TAG_W-1:0] resTag;
    logic             busy;

    exp_t expQ[$];
    int   nChecks = 0;
    int   nFails  = 0;
    int   startCount = 0;
    int   stableErr  = 0;

    div_issue_ctrl #(.XLEN(XLEN), .TAG_W(TAG_W), .DEPTH(2)) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .clk_en_i       (clkEn),
        .flush_i        (flush),
        .req_valid_i    (reqValid),
        .req_ready_o    (reqReady),
        .req_op_i       (reqOp),
        .req_dividend_i (reqDividend),
        .req_divisor_i  (reqDivisor),
        .req_tag_i      (reqTag),
        .div_start_o    (divStart),
        .div_op_o       (divOp),
        .div_dividend_o (divDividend),
        .div_divisor_o  (divDivisor),
        .div_done_i     (divDone),
        .div_result_i   (divResult),
        .res_valid_o    (resValid),
        .res_ready_i    (resReady),
        .res_data_o     (resData),
        .res_tag_o      (resTag),
        .busy_o         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // This is the reference arithmetic for ops the divider actually receives.
    // SystemVerilog signed / and % truncate toward zero, which matches RISC-V.
    function automatic logic [XLEN-1:0] refDivide(input logic [1:0] op,
                                                  input logic [XLEN-1:0] a,
                                                  input logic [XLEN-1:0] b);
        logic signed [XLEN-1:0] sa;
        logic signed [XLEN-1:0] sb;
        sa = a;
        sb = b;
        case (op)
            OP_DIV:  return sa / sb;
            OP_DIVU: return a / b;
            OP_REM:  return sa % sb;
            default: return a % b;
        endcase
    endfunction

    // This is the behavioural divider. It latches operands on the start pulse
    // and pulses done DIV_LAT cycles later. While it is busy it checks that the
    // held operands do not move. It forgets everything on reset, like the
    // real unit.
    logic [1:0]      mOp;
    logic [XLEN-1:0] mA, mB;
    int              mCnt = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            mCnt    = 0;
            divDone = 1'b0;
        end else begin
            divDone = 1'b0;
            if (mCnt > 0) begin
                if (divOp !== mOp || divDividend !== mA || divDivisor !== mB) begin
                    stableErr++;
                end
                mCnt--;
                if (mCnt == 0) begin
                    divDone   = 1'b1;
                    divResult = refDivide(mOp, mA, mB);
                end
            end
            if (divStart) begin
                startCount++;
                mOp  = divOp;
                mA   = divDividend;
                mB   = divDivisor;
                mCnt = DIV_LAT;
            end
        end
    end

    // This is the single comparison point. Every check goes through here.
    task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] expv);
        nChecks++;
        assert (obs === expv) else begin
            nFails++;
            $error("[TB] FAIL %s: observed %h expected %h", name, obs, expv);
        end
    endtask

    // This drives one request at a negedge once ready is seen, and optionally
    // queues its expected result. It returns at the following negedge.
    task automatic applyStimulus(input logic [1:0] op, input logic [XLEN-1:0] a,
                                 input logic [XLEN-1:0] b, input logic [TAG_W-1:0] tag,
                                 input logic [XLEN-1:0] expData, input bit track);
        exp_t e;
        for (int i = 0; i < 200; i++) begin
            if (reqReady) break;
            @(negedge clk);
        end
        checkOutput("push_ready", {31'd0, reqReady}, 32'd1);
        reqValid    = 1'b1;
        reqOp       = op;
        reqDividend = a;
        reqDivisor  = b;
        reqTag      = tag;
        if (track) begin
            e.tag  = tag;
            e.data = expData;
            expQ.push_back(e);
        end
        @(negedge clk);
        reqValid = 1'b0;
    endtask

    // This waits (bounded) for a result the bench will accept. It pops the
    // scoreboard, compares data and tag, then steps past the handshake edge.
    task automatic waitResult(input string name);
        exp_t e;
        for (int i = 0; i < 200; i++) begin
            if (resValid && resReady) break;
            @(negedge clk);
        end
        checkOutput({name, "_arrived"}, {31'd0, resValid}, 32'd1);
        if (resValid) begin
            checkOutput({name, "_queued"}, {31'd0, (expQ.size() > 0)}, 32'd1);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput({name, "_data"}, resData, e.data);
                checkOutput({name, "_tag"}, {28'd0, resTag}, {28'd0, e.tag});
            end
        end
        @(negedge clk);
    endtask

    // This handles a request that must be answered locally. The result must
    // appear exactly one cycle after the pop, and the divider is never started.
    task automatic doSpecial(input string name, input logic [1:0] op, input logic [XLEN-1:0] a,
                             input logic [XLEN-1:0] b, input logic [TAG_W-1:0] tag,
                             input logic [XLEN-1:0] expData);
        int s0;
        s0 = startCount;
        applyStimulus(op, a, b, tag, expData, 1'b1);
        checkOutput({name, "_pre"}, {31'd0, resValid}, 32'd0);
        @(negedge clk);
        checkOutput({name, "_lat"}, {31'd0, resValid}, 32'd1);
        waitResult(name);
        checkOutput({name, "_nolaunch"}, 32'(startCount - s0), 32'd0);
    endtask

    task automatic waitStart(input string name);
        for (int i = 0; i < 50; i++) begin
            if (divStart) break;
            @(negedge clk);
        end
        checkOutput({name, "_start"}, {31'd0, divStart}, 32'd1);
    endtask

    initial begin
        int s0;
        bit sawValid;
        rst_n       = 1'b0;
        clkEn       = 1'b1;
        flush       = 1'b0;
        reqValid    = 1'b0;
        reqOp       = '0;
        reqDividend = '0;
        reqDivisor  = '0;
        reqTag      = '0;
        resReady    = 1'b1;
        divDone     = 1'b0;
        divResult   = '0;
        repeat (2) @(negedge clk);

        $display("[TB] reset values");
        checkOutput("rst_req_ready", {31'd0, reqReady}, 32'd1);
        checkOutput("rst_res_valid", {31'd0, resValid}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_div_start", {31'd0, divStart}, 32'd0);
        checkOutput("rst_res_data", resData, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] clock enable freeze");
        clkEn       = 1'b0;
        reqValid    = 1'b1;
        reqOp       = OP_DIVU;
        reqDividend = 32'd5;
        reqDivisor  = 32'd0;
        repeat (3) @(negedge clk);
        checkOutput("clken_busy", {31'd0, busy}, 32'd0);
        reqValid = 1'b0;
        clkEn    = 1'b1;
        @(negedge clk);

        $display("[TB] normal DIV");
        s0 = startCount;
        applyStimulus(OP_DIV, 32'd100, 32'd7, 4'd3, 32'd14, 1'b1);
        checkOutput("div_busy", {31'd0, busy}, 32'd1);
        waitResult("div_norm");
        checkOutput("div_norm_starts", 32'(startCount - s0), 32'd1);

        $display("[TB] signed REM");
        s0 = startCount;
        applyStimulus(OP_REM, 32'hFFFFFF9C, 32'd7, 4'd4, 32'hFFFFFFFE, 1'b1);
        waitStart("rem");
        repeat (3) @(negedge clk);
        checkOutput("rem_div_op", {30'd0, divOp}, 32'd2);
        checkOutput("rem_div_dividend", divDividend, 32'hFFFFFF9C);
        checkOutput("rem_div_divisor", divDivisor, 32'd7);
        waitResult("rem_signed");
        checkOutput("rem_starts", 32'(startCount - s0), 32'd1);
        checkOutput("rem_stable", 32'(stableErr), 32'd0);

        $display("[TB] special cases");
        doSpecial("divu_zero", OP_DIVU, 32'd5, 32'd0, 4'd5, 32'hFFFFFFFF);
        doSpecial("remu_zero", OP_REMU, 32'd5, 32'd0, 4'd6, 32'd5);
        doSpecial("div_zero",  OP_DIV,  32'hFFFFFFF0, 32'd0, 4'd7, 32'hFFFFFFFF);
        doSpecial("rem_zero",  OP_REM,  32'hFFFFFFF0, 32'd0, 4'd8, 32'hFFFFFFF0);
        doSpecial("div_ovf",   OP_DIV,  32'h80000000, 32'hFFFFFFFF, 4'd9, 32'h80000000);
        doSpecial("rem_ovf",   OP_REM,  32'h80000000, 32'hFFFFFFFF, 4'd10, 32'd0);

        $display("[TB] DIVU of the overflow pattern still launches");
        s0 = startCount;
        applyStimulus(OP_DIVU, 32'h80000000, 32'hFFFFFFFF, 4'd11, 32'd0, 1'b1);
        waitResult("divu_big");
        checkOutput("divu_big_starts", 32'(startCount - s0), 32'd1);

        $display("[TB] backpressure");
        resReady = 1'b0;
        applyStimulus(OP_DIVU, 32'd7, 32'd0, 4'd0, 32'hFFFFFFFF, 1'b1);
        applyStimulus(OP_DIV, 32'd100, 32'd7, 4'd1, 32'd14, 1'b1);
        applyStimulus(OP_REMU, 32'd9, 32'd4, 4'd2, 32'd1, 1'b1);
        checkOutput("bp_ready_low", {31'd0, reqReady}, 32'd0);
        repeat (3) @(negedge clk);
        checkOutput("bp_hold_valid", {31'd0, resValid}, 32'd1);
        checkOutput("bp_hold_tag", {28'd0, resTag}, 32'd0);
        checkOutput("bp_still_full", {31'd0, reqReady}, 32'd0);
        resReady = 1'b1;
        waitResult("bp0");
        waitResult("bp1");
        waitResult("bp2");
        checkOutput("bp_idle", {31'd0, busy}, 32'd0);

        $display("[TB] flush during WAIT");
        applyStimulus(OP_DIV, 32'd50, 32'd5, 4'd5, 32'd10, 1'b0);
        waitStart("flush");
        repeat (3) @(negedge clk);
        flush       = 1'b1;
        reqValid    = 1'b1;
        reqOp       = OP_DIVU;
        reqDividend = 32'd1;
        reqDivisor  = 32'd0;
        reqTag      = 4'd6;
        @(negedge clk);
        flush    = 1'b0;
        reqValid = 1'b0;
        checkOutput("flush_drain_busy", {31'd0, busy}, 32'd1);
        sawValid = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (resValid) sawValid = 1'b1;
        end
        checkOutput("flush_no_valid", {31'd0, sawValid}, 32'd0);
        checkOutput("flush_busy_done", {31'd0, busy}, 32'd0);
        checkOutput("flush_ready", {31'd0, reqReady}, 32'd1);

        $display("[TB] reset during LAUNCH");
        applyStimulus(OP_DIV, 32'd100, 32'd7, 4'd9, 32'd14, 1'b0);
        waitStart("rst");
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("rst2_div_start", {31'd0, divStart}, 32'd0);
        checkOutput("rst2_res_valid", {31'd0, resValid}, 32'd0);
        checkOutput("rst2_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst2_req_ready", {31'd0, reqReady}, 32'd1);
        checkOutput("rst2_div_op", {30'd0, divOp}, 32'd0);
        checkOutput("rst2_div_dividend", divDividend, 32'd0);
        checkOutput("rst2_div_divisor", divDivisor, 32'd0);
        checkOutput("rst2_res_data", resData, 32'd0);
        checkOutput("rst2_res_tag", {28'd0, resTag}, 32'd0);
        rst_n = 1'b1;
        sawValid = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (resValid) sawValid = 1'b1;
        end
        checkOutput("rst2_no_valid", {31'd0, sawValid}, 32'd0);
        checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);

        $display("[TB] == %0d vectors applied, %0d miscompares ==", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/div_issue_ctrl.md
Name: div_issue_ctrl

Overview:
- Issue/sequencing stage directly upstream of the iterative divider in the M-extension execution path.
- Accepts tagged DIV/DIVU/REM/REMU requests from the issue logic into a small FIFO and launches them one at a time into the divider.
- Resolves RISC-V corner cases (divide-by-zero, signed overflow) locally without launching the divider.
- Returns one tagged result per request to writeback through a valid/ready handshake.

Parameters:
XLEN, 32, operand/result width
TAG_W, 4, request tag width (ROB index)
DEPTH, 2, request FIFO entries (power of 2, >=2)

Ports:
clk_i  in  1  clock, rising edge
rst_n_i  in  1  synchronous reset, active low
clk_en_i  in  1  clock enable; low freezes all state
flush_i  in  1  pipeline flush
req_valid_i  in  1  request valid
req_ready_o  out  1  FIFO not full
req_op_i  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
req_dividend_i  in  XLEN  rs1
req_divisor_i  in  XLEN  rs2
req_tag_i  in  TAG_W  destination tag
div_start_o  out  1  one-cycle launch pulse to divider
div_op_o  out  2  operation to divider
div_dividend_o  out  XLEN  held stable from launch until done
div_divisor_o  out  XLEN  held stable from launch until done
div_done_i  in  1  divider result valid pulse
div_result_i  in  XLEN  divider result, sampled when div_done_i=1
res_valid_o  out  1  result valid
res_ready_i  in  1  writeback accepts
res_data_o  out  XLEN  result
res_tag_o  out  TAG_W  tag of result
busy_o  out  1  FSM not IDLE or FIFO not empty

Behaviour:
- Clock and reset: one clock clk_i; reset is synchronous and active-low on rst_n_i.
- Reset and clock enable: reset has priority over clk_en_i. All registers update only when clk_en_i=1, except reset.
- Reset values:
  - FIFO empty; FSM IDLE.
  - req_ready_o=1 after reset.
  - div_start_o=0, res_valid_o=0, busy_o=0.
  - res_data_o, res_tag_o, div_op_o, div_dividend_o, div_divisor_o all 0.
- FIFO:
  - Push on req_valid_i & req_ready_o.
  - req_ready_o = !full, combinational from the count only.
  - Push and pop in the same cycle are allowed; count is unchanged.
  - No push is possible when full.
  - Pointers wrap modulo DEPTH.
- FSM states:
  - IDLE: if FIFO is non-empty, pop the head.
    - Special case: go to RESULT, with the result register loaded on the pop edge.
    - Otherwise: latch operands/op into the div_* registers and go to LAUNCH.
  - LAUNCH: div_start_o=1 for exactly this cycle; go to WAIT.
  - WAIT: on div_done_i, capture div_result_i and the held tag, then go to RESULT.
  - RESULT: res_valid_o=1; data/tag stable until res_valid_o & res_ready_i.
    - On handshake, go to IDLE. No head-of-FIFO pop occurs in that same cycle; the minimum issue interval is 2 cycles.
  - DRAIN: entered from LAUNCH/WAIT on flush; wait for div_done_i, discard the result, then go to IDLE. div_start_o=0.
- Special cases (32-bit values shown), decided at pop:
  - divisor==0:
    - DIV/DIVU -> all ones (0xFFFFFFFF).
    - REM/REMU -> dividend.
  - DIV with dividend=0x80000000 and divisor=0xFFFFFFFF -> 0x80000000.
  - REM with the same operands -> 0.
  - DIVU/REMU are never overflow.
- Latency:
  - Special case: result valid one cycle after the pop.
  - Normal case: launch is one cycle after the pop; result valid one cycle after div_done_i.
- div_done_i outside WAIT/DRAIN is ignored.
- flush_i (with clk_en_i=1):
  - FIFO is emptied; a push in the same cycle is dropped.
  - RESULT and IDLE go to IDLE with res_valid_o=0 on the next cycle.
  - LAUNCH and WAIT go to DRAIN.
  - Flush in DRAIN: stays in DRAIN.
- Reset mid-operation: everything returns to reset values on the next edge. Any divider result still in flight is ignored; the divider is reset by the same rst_n_i.
- busy_o is combinational: (state!=IDLE) | !empty.

Test Plan:
- Normal DIV: DIV 100/7 tag 3, model divider done 34 cycles after start with 14 -> one div_start_o pulse, res_data_o=14, res_tag_o=3.
- Signed REM: REM 0xFFFFFF9C (-100) / 7 -> divider launched with op 10; result returned as supplied (0xFFFFFFFE); operands stable throughout WAIT.
- Divide by zero: DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; each valid one cycle after pop; no div_start_o.
- Overflow: DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0; no launch.
- Backpressure: push 3 requests back-to-back with res_ready_i=0 -> req_ready_o drops after 2 entries are buffered; results emerge in order, tags 0,1,2, after ready is raised.
- Flush/reset: flush during WAIT -> the next done is discarded, no res_valid_o, FIFO empty, busy_o=0 after done. rst_n_i=0 during LAUNCH -> all outputs at reset values next cycle.
